// File: rtl/mem_seq_arbiter.sv
// mem_seq_arbiter
// Sequences a single-cycle MIPS datapath onto one shared single-port memory
// bus. Instruction fetch and data access run as separate bus phases. The
// fetched word is held stable while the datapath works on it, and each
// instruction ends with exactly one cpu_en commit pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for run, or for a step pulse
// FETCH  | bus read of the instruction word at inst_addr
// DECODE | datapath settles on inst_data; data request is sampled
// DATA   | bus load or store at dmem_addr
// COMMIT | one-cycle cpu_en; retired count advances
// FAULT  | sticky until reset; fault_code holds the cause
module mem_seq_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  cpu_rst_n,
  input  logic                  run,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  dmem_ren,
  input  logic                  dmem_wen,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  cpu_en,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  busy,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [31:0]           retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [1:0] FC_TIMEOUT  = 2'd1;
  localparam logic [1:0] FC_ALIGN    = 2'd2;
  localparam logic [1:0] FC_CONFLICT = 2'd3;
  localparam logic [7:0] TMO_LIMIT   = 8'(TIMEOUT_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_fault_code;
  logic [1:0]            w_fault_code_nxt;
  logic [7:0]            r_tmo_cnt;
  logic [7:0]            w_tmo_inc;
  logic                  w_tmo_hit;
  logic                  r_data_wr;
  logic [DATA_WIDTH-1:0] r_inst_data;
  logic [DATA_WIDTH-1:0] r_dmem_rdata;
  logic [31:0]           r_retired;
  logic                  w_inst_mis;
  logic                  w_data_mis;
  logic                  w_data_any;

  assign w_inst_mis = (inst_addr[1:0] != 2'b00);
  assign w_data_mis = (dmem_addr[1:0] != 2'b00);
  assign w_data_any = dmem_ren | dmem_wen;

  // The limit compares against the count after this cycle's increment, so a
  // phase gets exactly TIMEOUT_CYCLES ack-less edges before it faults.
  assign w_tmo_inc = r_tmo_cnt + 8'd1;
  assign w_tmo_hit = (w_tmo_inc == TMO_LIMIT);

  // State and fault-cause register.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state      <= S_IDLE;
      r_fault_code <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_fault_code <= w_fault_code_nxt;
    end
  end

  // Next-state decode and bus/commit outputs, all derived from the state.
  always_comb begin
    w_state_nxt      = r_state;
    w_fault_code_nxt = r_fault_code;
    bus_req          = 1'b0;
    bus_we           = 1'b0;
    bus_addr         = '0;
    bus_wdata        = '0;
    cpu_en           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run || step) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // A misaligned PC is never put on the bus.
        bus_req  = ~w_inst_mis;
        bus_addr = {inst_addr[ADDR_WIDTH-1:2], 2'b00};
        if (w_inst_mis) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = FC_ALIGN;
        end else if (bus_ack) begin
          w_state_nxt = S_DECODE;
        end else if (w_tmo_hit) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dmem_ren && dmem_wen) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = FC_CONFLICT;
        end else if (w_data_any && w_data_mis) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = FC_ALIGN;
        end else if (w_data_any) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_DATA: begin
        bus_req   = 1'b1;
        bus_we    = r_data_wr;
        bus_addr  = {dmem_addr[ADDR_WIDTH-1:2], 2'b00};
        bus_wdata = dmem_wdata;
        if (bus_ack) begin
          w_state_nxt = S_COMMIT;
        end else if (w_tmo_hit) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = FC_TIMEOUT;
        end
      end
      S_COMMIT: begin
        cpu_en      = 1'b1;
        w_state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Ack-wait counter: restarts on every state change, counts while waiting.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state != w_state_nxt) begin
      r_tmo_cnt <= 8'd0;
    end else if ((r_state == S_FETCH) || (r_state == S_DATA)) begin
      r_tmo_cnt <= w_tmo_inc;
    end
  end

  // Direction of the data phase is frozen when DECODE hands over to DATA.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_data_wr <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_data_wr <= dmem_wen;
    end
  end

  // Instruction and load-data holding latches.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_inst_data  <= '0;
      r_dmem_rdata <= '0;
    end else begin
      if ((r_state == S_FETCH) && bus_ack && !w_inst_mis) r_inst_data <= bus_rdata;
      if ((r_state == S_DATA) && bus_ack && !r_data_wr) r_dmem_rdata <= bus_rdata;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_retired <= 32'd0;
    end else if (r_state == S_COMMIT) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign inst_data  = r_inst_data;
  assign dmem_rdata = r_dmem_rdata;
  assign retired    = r_retired;
  assign fault      = (r_state == S_FAULT);
  assign fault_code = r_fault_code;
  assign busy       = (r_state != S_IDLE) && (r_state != S_FAULT);

endmodule

// File: tb/tb_mem_seq_arbiter.sv
// tb_mem_seq_arbiter
// The bench acts as the bus slave and the datapath. The reference model
// predicts each instruction's outcome from its shape alone: the bus phases,
// the commit latency, any fault, and the held data words.
module tb_mem_seq_arbiter;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        cpu_rst_n;
  logic        run;
  logic        step;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        cpu_en;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_retired;
  logic [31:0] m_inst;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  mem_seq_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk        (clk),
    .cpu_rst_n  (cpu_rst_n),
    .run        (run),
    .step       (step),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .dmem_ren   (dmem_ren),
    .dmem_wen   (dmem_wen),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .cpu_en     (cpu_en),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .busy       (busy),
    .fault      (fault),
    .fault_code (fault_code),
    .retired    (retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    cpu_rst_n = 1'b0;
    run = 1'b0; step = 1'b0; bus_ack = 1'b0;
    dmem_ren = 1'b0; dmem_wen = 1'b0;
    #1;
    chk("rst_ctrl", 32'({bus_req, bus_we, cpu_en, busy, fault, fault_code}), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    m_retired = 32'd0; m_inst = 32'd0; m_rdata = 32'd0;
    @(negedge clk);
    cpu_rst_n = 1'b1;
  endtask

  // One instruction. fw/dw are ack wait cycles for fetch/data; a value of
  // TMO or more means the ack never comes. chained: the DUT is already in
  // FETCH cycle 1 of this instruction. drop_run: run falls mid-instruction.
  task automatic do_instr(input logic [31:0] ia, input bit rd, input bit wr,
                          input logic [31:0] da, input logic [31:0] wd,
                          input int fw, input int dw,
                          input logic [31:0] iword, input logic [31:0] dword,
                          input bit use_run, input bit chained, input bit drop_run);
    int cyc, phase, waited, data_reqs, exp_lat, exp_fcyc, exp_dreqs;
    logic [1:0] exp_fc;
    bit done;

    exp_lat   = 3 + fw + ((rd || wr) ? 1 + dw : 0);
    exp_fc    = 2'd0;
    exp_fcyc  = 0;
    exp_dreqs = 0;
    if (ia[1:0] != 2'b00) begin
      exp_fc = 2'd2; exp_fcyc = 2;
    end else if (fw >= TMO) begin
      exp_fc = 2'd1; exp_fcyc = 1 + TMO;
    end else if (rd && wr) begin
      exp_fc = 2'd3; exp_fcyc = 3 + fw;
    end else if ((rd || wr) && da[1:0] != 2'b00) begin
      exp_fc = 2'd2; exp_fcyc = 3 + fw;
    end else if ((rd || wr) && dw >= TMO) begin
      exp_fc = 2'd1; exp_fcyc = 3 + fw + TMO; exp_dreqs = TMO;
    end else if (rd || wr) begin
      exp_dreqs = dw + 1;
    end

    inst_addr = ia; dmem_ren = rd; dmem_wen = wr; dmem_addr = da; dmem_wdata = wd;
    run = use_run;
    step = !use_run;
    #1;
    if (!chained) begin
      @(posedge clk);
      #1 step = 1'b0;
      @(negedge clk);
    end
    cyc = 1; phase = 0; waited = 0; data_reqs = 0; done = 0;
    while (!done && cyc < 800) begin
      bus_ack = 1'b0;
      if (fault || cpu_en) begin
        done = 1;
      end else begin
        if (bus_req) begin
          if (phase == 0) begin
            chk("fetch_addr", bus_addr, {ia[31:2], 2'b00});
            chk("fetch_we", 32'(bus_we), 32'd0);
            if (waited == fw) begin
              bus_ack = 1'b1; bus_rdata = iword; phase = 1; waited = 0;
            end else begin
              bus_rdata = $urandom; waited++;
            end
          end else begin
            data_reqs++;
            if (drop_run) run = 1'b0;
            chk("data_addr", bus_addr, da);
            chk("data_we", 32'(bus_we), 32'(wr));
            if (wr) chk("data_wdata", bus_wdata, wd);
            if (waited == dw) begin
              bus_ack = 1'b1; bus_rdata = dword; phase = 2; waited = 0;
            end else begin
              bus_rdata = $urandom; waited++;
            end
          end
        end else if (drop_run && !(rd || wr)) begin
          run = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    bus_ack = 1'b0;
    chk("finished", 32'(done), 32'd1);
    chk("data_reqs", 32'(data_reqs), 32'(exp_dreqs));
    if (exp_fc != 2'd0) begin
      chk("fault_cyc", 32'(cyc), 32'(exp_fcyc));
      chk("fault_state", 32'({fault, fault_code, cpu_en, bus_req, busy}), 32'({1'b1, exp_fc, 3'b000}));
      repeat (3) @(negedge clk);
      chk("fault_sticky", 32'({fault, fault_code, cpu_en}), 32'({1'b1, exp_fc, 1'b0}));
    end else begin
      chk("commit_cyc", 32'(cyc), 32'(exp_lat));
      chk("retired_pre", retired, m_retired);
      @(negedge clk);
      m_retired = m_retired + 32'd1;
      m_inst    = iword;
      if (rd) m_rdata = dword;
      chk("retired", retired, m_retired);
      chk("inst_data", inst_data, m_inst);
      chk("dmem_rdata", dmem_rdata, m_rdata);
      chk("en_once", 32'(cpu_en), 32'd0);
      chk("after_commit", 32'({bus_req, busy}), 32'({run, run}));
    end
  endtask

  initial begin
    int en_cnt, busy_cnt, sel;
    logic [31:0] base;

    cpu_rst_n = 1'b0; run = 1'b0; step = 1'b0;
    inst_addr = '0; dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    m_retired = '0; m_inst = '0; m_rdata = '0;
    do_reset();

    // One retired instruction, then reset in the middle of a fetch.
    do_instr(32'h10, 1'b1, 1'b0, 32'h200, 32'h0, 0, 0, 32'h8C010200, 32'hCAFE0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    inst_addr = 32'h40; step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (3) @(negedge clk);
    chk("midfetch_req", 32'(bus_req), 32'd1);
    #2 cpu_rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'({bus_req, busy, cpu_en}), 32'd0);
    chk("async_retired", retired, 32'd0);
    chk("async_inst_data", inst_data, 32'd0);
    do_reset();

    // Free-running: zero-wait add, lw with 2 waits, sw with run dropped in DATA.
    do_instr(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h01095020, 32'h0, 1'b1, 1'b0, 1'b0);
    do_instr(32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 0, 2, 32'h8C080100, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    do_instr(32'h8, 1'b0, 1'b1, 32'h104, 32'h12345678, 0, 0, 32'hAC080104, $urandom, 1'b1, 1'b1, 1'b1);

    // Three single steps, ten idle cycles apart.
    base = m_retired;
    for (int i = 0; i < 3; i++) begin
      do_instr(32'h100 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, $urandom_range(0, 2), 0,
               $urandom, 32'h0, 1'b0, 1'b0, 1'b0);
      en_cnt = 0; busy_cnt = 0;
      repeat (10) begin
        @(negedge clk);
        if (cpu_en) en_cnt++;
        if (busy) busy_cnt++;
      end
      chk("gap_en", 32'(en_cnt), 32'd0);
      chk("gap_busy", 32'(busy_cnt), 32'd0);
    end
    chk("step_retired", retired, base + 32'd3);

    // Random single steps.
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 2);
      do_instr($urandom & 32'hFFFF_FFFC, sel == 1, sel == 2, $urandom & 32'hFFFF_FFFC, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    end

    // Random free-running burst, run dropped during the last instruction.
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 2);
      do_instr($urandom & 32'hFFFF_FFFC, sel == 1, sel == 2, $urandom & 32'hFFFF_FFFC, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom,
               1'b1, i != 0, i == 7);
    end

    // Ack on the very cycle the limit is reached wins, for both phases.
    do_instr(32'h20, 1'b0, 1'b0, 32'h0, 32'h0, TMO - 1, 0, $urandom, 32'h0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h24, 1'b1, 1'b0, 32'h300, 32'h0, 0, TMO - 1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);

    // Faults.
    do_instr(32'h28, 1'b0, 1'b0, 32'h0, 32'h0, 1000, 0, $urandom, 32'h0, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_instr(32'h2C, 1'b1, 1'b0, 32'h102, 32'h0, 1, 0, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_instr(32'h30, 1'b1, 1'b1, 32'h108, 32'h0, 0, 0, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_instr(32'h42, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, $urandom, 32'h0, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_instr(32'h34, 1'b0, 1'b1, 32'h10C, 32'h55AA55AA, 0, 1000, $urandom, 32'h0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Still usable after a fault-and-reset cycle.
    do_instr(32'h38, 1'b1, 1'b0, 32'h110, 32'h0, 1, 1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
